// File: rtl/sync_debounce_pkg.sv
// Shared definitions for the clkB-domain level debouncer: FSM state
// encodings and glitch-counter geometry.
package sync_debounce_pkg;

  typedef logic [1:0] state_t;

  // Stable states carry the accepted level; candidate states hold the old one.
  localparam logic [1:0] ST_LO  = 2'b00;
  localparam logic [1:0] CHK_HI = 2'b01;
  localparam logic [1:0] ST_HI  = 2'b10;
  localparam logic [1:0] CHK_LO = 2'b11;

  // Rejected-glitch counter width and the value it sticks at.
  localparam int                  GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/sync_edge_pulse.sv
// Clean-level register with rise/fall pulse generation for clkB consumers.
// The block owns the level flop, so the previous level is its delayed copy.
// The pulse is therefore registered on the same edge the level changes, and
// all three outputs come straight from flops.
module sync_edge_pulse #(
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic clkB,
  input  logic rstB_n,
  input  logic LevelNext_clkB,
  output logic Level_clkB,
  output logic Rise_clkB,
  output logic Fall_clkB
);

  // Capture the new level and flag the direction of any change
  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      Level_clkB <= INIT_LEVEL;
      Rise_clkB  <= 1'b0;
      Fall_clkB  <= 1'b0;
    end else begin
      Level_clkB <= LevelNext_clkB;
      Rise_clkB  <= LevelNext_clkB & ~Level_clkB;
      Fall_clkB  <= ~LevelNext_clkB & Level_clkB;
    end
  end

endmodule

// File: rtl/sync_level_debounce.sv
// Debounces an already-synchronized clkB level.
// A new level is accepted only after STABLE_CYCLES consecutive matching samples.
// Optional macro SYNC_DEBOUNCE_GLITCH_CNT_EN adds a saturating rejected-glitch
// counter, together with its GlitchClr_clkB and GlitchCnt_clkB ports.
module sync_level_debounce
  import sync_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter bit          INIT_LEVEL    = 1'b0
) (
  input  logic                clkB,
  input  logic                rstB_n,
  input  logic                SignalSync_clkB,
  output logic                Level_clkB,
  output logic                Rise_clkB,
  output logic                Fall_clkB
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  input  logic                GlitchClr_clkB,
  output logic [GLITCH_W-1:0] GlitchCnt_clkB
`endif
);

  localparam int               CNT_W      = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RST_STATE  = INIT_LEVEL ? ST_HI : ST_LO;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             levelNext;

  // Next-state and run-length counter; cnt stops at CNT_LAST and never wraps
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      ST_LO: begin
        if (SignalSync_clkB) begin
          stateNext = CHK_HI;
          cntNext   = CNT_W'(1);
        end
      end
      CHK_HI: begin
        if (!SignalSync_clkB) begin
          stateNext = ST_LO;
          cntNext   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNext = ST_HI;
          cntNext   = '0;
        end else begin
          cntNext   = cnt + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!SignalSync_clkB) begin
          stateNext = CHK_LO;
          cntNext   = CNT_W'(1);
        end
      end
      CHK_LO: begin
        if (SignalSync_clkB) begin
          stateNext = ST_HI;
          cntNext   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNext = ST_LO;
          cntNext   = '0;
        end else begin
          cntNext   = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = RST_STATE;
        cntNext   = '0;
      end
    endcase
  end

  // Clean level is high in ST_HI and while a drop is still being qualified
  always_comb begin
    levelNext = (stateNext == ST_HI) || (stateNext == CHK_LO);
  end

  // FSM state and counter registers; reset discards any candidate in flight
  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  sync_edge_pulse #(
    .INIT_LEVEL (INIT_LEVEL)
  ) uEdgePulse (
    .clkB           (clkB),
    .rstB_n         (rstB_n),
    .LevelNext_clkB (levelNext),
    .Level_clkB     (Level_clkB),
    .Rise_clkB      (Rise_clkB),
    .Fall_clkB      (Fall_clkB)
  );

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic glitchEvt;

  // A glitch is a candidate that falls back to the stable state it left
  always_comb begin
    glitchEvt = ((state == CHK_HI) && !SignalSync_clkB) ||
                ((state == CHK_LO) &&  SignalSync_clkB);
  end

  // Saturating glitch counter; clear wins over a same-edge increment
  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      GlitchCnt_clkB <= '0;
    end else if (GlitchClr_clkB) begin
      GlitchCnt_clkB <= '0;
    end else if (glitchEvt && (GlitchCnt_clkB != GLITCH_MAX)) begin
      GlitchCnt_clkB <= GlitchCnt_clkB + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sync_level_debounce.sv
// Directed bench for sync_level_debounce with STABLE_CYCLES=4.
// Two instances are used: dut0 (INIT_LEVEL=0) and dut1 (INIT_LEVEL=1).
module tb_sync_level_debounce;

  logic clkB = 1'b0;
  logic rst0_n, rst1_n;
  logic sig0, sig1;
  logic lvl0, rise0, fall0;
  logic lvl1, rise1, fall1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic       clr0, clr1;
  logic [7:0] gc0, gc1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clkB = ~clkB;

  sync_level_debounce #(.STABLE_CYCLES(4), .INIT_LEVEL(1'b0)) dut0 (
    .clkB            (clkB),
    .rstB_n          (rst0_n),
    .SignalSync_clkB (sig0),
    .Level_clkB      (lvl0),
    .Rise_clkB       (rise0),
    .Fall_clkB       (fall0)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .GlitchClr_clkB  (clr0),
    .GlitchCnt_clkB  (gc0)
`endif
  );

  sync_level_debounce #(.STABLE_CYCLES(4), .INIT_LEVEL(1'b1)) dut1 (
    .clkB            (clkB),
    .rstB_n          (rst1_n),
    .SignalSync_clkB (sig1),
    .Level_clkB      (lvl1),
    .Rise_clkB       (rise1),
    .Fall_clkB       (fall1)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .GlitchClr_clkB  (clr1),
    .GlitchCnt_clkB  (gc1)
`endif
  );

  task automatic tick();
    @(posedge clkB);
    #1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    sig0   = 1'b0;
    sig1   = 1'b1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    clr0 = 1'b0;
    clr1 = 1'b0;
`endif
    #12;
    checks++;
    if (lvl0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut0 got lvl/rise/fall=%b%b%b want 000", lvl0, rise0, fall0);
    end
    checks++;
    if (lvl1 !== 1'b1 || rise1 !== 1'b0 || fall1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1 got lvl/rise/fall=%b%b%b want 100", lvl1, rise1, fall1);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gc0 !== 8'd0 || gc1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_glitchcnt got %0d/%0d want 0/0", gc0, gc1);
    end
`endif
    tick();
    rst0_n = 1'b1;
    rst1_n = 1'b1;
  endtask

  // dut0: input goes high before edge 0; level and rise on edge 3 only
  task automatic test_rise();
    sig0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (lvl0 !== (i >= 3) || rise0 !== (i == 3) || fall0 !== 1'b0) begin
        errors++;
        $display("FAIL rise edge%0d got lvl/rise/fall=%b%b%b want %b%b0",
                 i, lvl0, rise0, fall0, (i >= 3), (i == 3));
      end
    end
  endtask

  // dut0: drop to 0 for 4 samples; level falls on the 4th, fall pulse once
  task automatic test_fall();
    sig0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (lvl0 !== (i < 3) || fall0 !== (i == 3) || rise0 !== 1'b0) begin
        errors++;
        $display("FAIL fall edge%0d got lvl/rise/fall=%b%b%b want %b0%b",
                 i, lvl0, rise0, fall0, (i < 3), (i == 3));
      end
    end
  endtask

  // dut0: high for only 3 samples is rejected and counted as one glitch
  task automatic test_glitch();
    for (int i = 0; i < 5; i++) begin
      sig0 = (i < 3);
      tick();
      checks++;
      if (lvl0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge%0d got lvl/rise/fall=%b%b%b want 000",
                 i, lvl0, rise0, fall0);
      end
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gc0 !== 8'd1) begin
      errors++;
      $display("FAIL glitch_count got %0d want 1", gc0);
    end
`endif
  endtask

  // dut1: released high holds without rise; a released-low input falls after 4 samples
  task automatic test_init_high();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (lvl1 !== 1'b1 || rise1 !== 1'b0 || fall1 !== 1'b0) begin
        errors++;
        $display("FAIL init_high_hold edge%0d got lvl/rise/fall=%b%b%b want 100",
                 i, lvl1, rise1, fall1);
      end
    end
    rst1_n = 1'b0;
    sig1   = 1'b0;
    tick();
    rst1_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (lvl1 !== (i < 3) || fall1 !== (i == 3) || rise1 !== 1'b0) begin
        errors++;
        $display("FAIL init_high_fall edge%0d got lvl/rise/fall=%b%b%b want %b0%b",
                 i, lvl1, rise1, fall1, (i < 3), (i == 3));
      end
    end
  endtask

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  // dut0: saturate at 255, then clear on the same edge as another glitch
  task automatic test_glitch_sat();
    int sawPulse;
    sawPulse = 0;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    checks++;
    if (gc0 !== 8'd0) begin
      errors++;
      $display("FAIL glitch_preclear got %0d want 0", gc0);
    end
    for (int g = 0; g < 300; g++) begin
      sig0 = 1'b1;
      tick();
      if (rise0 || fall0 || lvl0) sawPulse++;
      sig0 = 1'b0;
      tick();
      if (rise0 || fall0 || lvl0) sawPulse++;
    end
    checks++;
    if (gc0 !== 8'd255) begin
      errors++;
      $display("FAIL glitch_saturate got %0d want 255", gc0);
    end
    checks++;
    if (sawPulse !== 0) begin
      errors++;
      $display("FAIL glitch_storm_quiet got %0d nonzero cycles want 0", sawPulse);
    end
    sig0 = 1'b1;
    tick();
    sig0 = 1'b0;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    checks++;
    if (gc0 !== 8'd0) begin
      errors++;
      $display("FAIL glitch_clear_priority got %0d want 0", gc0);
    end
    tick();
    checks++;
    if (gc0 !== 8'd0) begin
      errors++;
      $display("FAIL glitch_after_clear got %0d want 0", gc0);
    end
  endtask
`endif

  // dut0: async reset mid-check at cnt=2 restarts the full window
  task automatic test_async_reset();
    sig0 = 1'b1;
    tick();
    tick();
    #2;
    rst0_n = 1'b0;
    #1;
    checks++;
    if (lvl0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
      errors++;
      $display("FAIL async_midcheck got lvl/rise/fall=%b%b%b want 000", lvl0, rise0, fall0);
    end
    tick();
    rst0_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (lvl0 !== (i >= 3) || rise0 !== (i == 3) || fall0 !== 1'b0) begin
        errors++;
        $display("FAIL async_rewindow edge%0d got lvl/rise/fall=%b%b%b want %b%b0",
                 i, lvl0, rise0, fall0, (i >= 3), (i == 3));
      end
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (gc0 !== 8'd0) begin
      errors++;
      $display("FAIL async_no_glitch got %0d want 0", gc0);
    end
`endif
    // Level is high now; reset between edges must drop it without a clock
    #3;
    rst0_n = 1'b0;
    #1;
    checks++;
    if (lvl0 !== 1'b0 || fall0 !== 1'b0) begin
      errors++;
      $display("FAIL async_level_drop got lvl/fall=%b%b want 00", lvl0, fall0);
    end
    tick();
    rst0_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_init_high();
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    test_glitch_sat();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
